// File: rtl/iguana_pinmux.sv
// iguana_pinmux -- register-programmable pad multiplexer.
//
// Each pad is owned by one of NumFunc peripheral functions (function 0 is
// GPIO). The owner is chosen through a small register slave. Changing the
// owner passes the pin through a drain phase of SwitchGap cycles. During the
// drain the pad driver is off and every function sees its idle input, so two
// functions never drive the pad back to back. Pad inputs go through an
// optional SyncStages-deep synchroniser.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   reg_valid_i          request valid (held by master until reg_ready_o)
//   reg_write_i          1 = write, 0 = read
//   reg_addr_i           byte address relative to block base
//   reg_wdata_i          write data
//   reg_ready_o          one-cycle response strobe
//   reg_rdata_o          read data, valid with reg_ready_o
//   reg_error_o          error flag, valid with reg_ready_o
//   func_o_i/func_oe_i   per-function output value / enable, [func][pin]
//   func_i_o             per-function input value, [func][pin]
//   pad_i                pad input
//   pad_o/pad_oe_o       pad output value / enable
//
// Per-pin state
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_ACTIVE | r_sel owns the pad; outputs and input routed to it
//   ST_DRAIN  | pad off, all inputs idle; r_cnt counts down to the switch
//             | to r_tgt (a new write reloads the counter)

module iguana_pinmux #(
   parameter int                 NumPins    = 32,
   parameter int                 NumFunc    = 4,
   parameter int                 FuncW      = (NumFunc > 1) ? $clog2(NumFunc) : 1,
   parameter int                 SwitchGap  = 4,
   parameter int                 SyncStages = 2,
   parameter logic [NumFunc-1:0] FuncIdleIn = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              reg_valid_i,
   input  logic                              reg_write_i,
   input  logic [31:0]                       reg_addr_i,
   input  logic [31:0]                       reg_wdata_i,
   output logic                              reg_ready_o,
   output logic [31:0]                       reg_rdata_o,
   output logic                              reg_error_o,
   input  logic [NumFunc-1:0][NumPins-1:0]   func_o_i,
   input  logic [NumFunc-1:0][NumPins-1:0]   func_oe_i,
   output logic [NumFunc-1:0][NumPins-1:0]   func_i_o,
   input  logic [NumPins-1:0]                pad_i,
   output logic [NumPins-1:0]                pad_o,
   output logic [NumPins-1:0]                pad_oe_o
);

   localparam int              CntW    = (SwitchGap > 1) ? $clog2(SwitchGap) : 1;
   localparam int              PinW    = (NumPins > 1) ? $clog2(NumPins) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(SwitchGap - 1);

   typedef enum logic {
      ST_ACTIVE = 1'b0,
      ST_DRAIN  = 1'b1
   } pin_state_e;

   pin_state_e       r_state     [NumPins];
   pin_state_e       w_state_nxt [NumPins];
   logic [CntW-1:0]  r_cnt       [NumPins];
   logic [CntW-1:0]  w_cnt_nxt   [NumPins];
   logic [FuncW-1:0] r_sel       [NumPins];
   logic [FuncW-1:0] w_sel_nxt   [NumPins];
   logic [FuncW-1:0] r_tgt       [NumPins];
   logic [FuncW-1:0] w_tgt_nxt   [NumPins];

   logic             r_ready, w_ready_nxt;
   logic [31:0]      r_rdata, w_rdata_nxt;
   logic             r_error, w_error_nxt;

   logic [NumPins-1:0] w_drain;
   logic [NumPins-1:0] w_pad_in;

   // Register decode
   logic             w_req;
   logic [29:0]      w_word;
   logic             w_aligned;
   logic             w_is_sel;
   logic             w_is_status;
   logic [PinW-1:0]  w_pin;
   logic [FuncW-1:0] w_wsel;
   logic             w_wdata_bad;

   assign w_req       = reg_valid_i & ~r_ready;
   assign w_word      = reg_addr_i[31:2];
   assign w_aligned   = (reg_addr_i[1:0] == 2'b00);
   assign w_is_sel    = w_aligned && (w_word < 30'(NumPins));
   assign w_is_status = w_aligned && (w_word == 30'(NumPins));
   assign w_pin       = w_word[PinW-1:0];
   assign w_wsel      = reg_wdata_i[FuncW-1:0];
   assign w_wdata_bad = ({{(32-FuncW){1'b0}}, w_wsel} >= 32'(NumFunc)) ||
                        ((reg_wdata_i >> FuncW) != 32'd0);

   // Pad input synchroniser; free-running, independent of the pin FSMs.
   generate
      if (SyncStages == 0) begin : g_nosync
         assign w_pad_in = pad_i;
      end else begin : g_sync
         logic [SyncStages-1:0][NumPins-1:0] r_sync;
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= pad_i;
               for (int s = 1; s < SyncStages; s++) begin
                  r_sync[s] <= r_sync[s-1];
               end
            end
         end
         assign w_pad_in = r_sync[SyncStages-1];
      end
   endgenerate

   always_comb begin
      for (int p = 0; p < NumPins; p++) begin
         w_drain[p] = (r_state[p] == ST_DRAIN);
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int p = 0; p < NumPins; p++) begin
            r_state[p] <= ST_ACTIVE;
            r_cnt[p]   <= '0;
            r_sel[p]   <= '0;
            r_tgt[p]   <= '0;
         end
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_error <= 1'b0;
      end else begin
         for (int p = 0; p < NumPins; p++) begin
            r_state[p] <= w_state_nxt[p];
            r_cnt[p]   <= w_cnt_nxt[p];
            r_sel[p]   <= w_sel_nxt[p];
            r_tgt[p]   <= w_tgt_nxt[p];
         end
         r_ready <= w_ready_nxt;
         r_rdata <= w_rdata_nxt;
         r_error <= w_error_nxt;
      end
   end

   // Next state: drain countdown first, then the register access, so a write
   // landing on the last drain cycle reloads the counter instead of switching.
   always_comb begin
      for (int p = 0; p < NumPins; p++) begin
         w_state_nxt[p] = r_state[p];
         w_cnt_nxt[p]   = r_cnt[p];
         w_sel_nxt[p]   = r_sel[p];
         w_tgt_nxt[p]   = r_tgt[p];
         if (r_state[p] == ST_DRAIN) begin
            if (r_cnt[p] == '0) begin
               w_state_nxt[p] = ST_ACTIVE;
               w_sel_nxt[p]   = r_tgt[p];
            end else begin
               w_cnt_nxt[p] = r_cnt[p] - CntW'(1);
            end
         end
      end

      w_ready_nxt = w_req;
      w_rdata_nxt = '0;
      w_error_nxt = 1'b0;

      if (w_req) begin
         if (w_is_status) begin
            if (reg_write_i) begin
               w_error_nxt = 1'b1;
            end else begin
               w_rdata_nxt = {31'd0, |w_drain};
            end
         end else if (!w_is_sel) begin
            w_error_nxt = 1'b1;
         end else if (!reg_write_i) begin
            w_rdata_nxt = {w_drain[w_pin], {(31-FuncW){1'b0}}, r_sel[w_pin]};
         end else if (w_wdata_bad) begin
            w_error_nxt = 1'b1;
         end else if (w_drain[w_pin] || (w_wsel != r_sel[w_pin])) begin
            // Same-value writes while draining still restart the drain.
            w_state_nxt[w_pin] = ST_DRAIN;
            w_cnt_nxt[w_pin]   = CntLoad;
            w_tgt_nxt[w_pin]   = w_wsel;
            w_sel_nxt[w_pin]   = r_sel[w_pin];
         end
      end
   end

   // Outputs
   always_comb begin
      for (int p = 0; p < NumPins; p++) begin
         for (int f = 0; f < NumFunc; f++) begin
            func_i_o[f][p] = FuncIdleIn[f];
         end
         pad_o[p]    = 1'b0;
         pad_oe_o[p] = 1'b0;
         if (!w_drain[p]) begin
            pad_o[p]             = func_o_i[r_sel[p]][p];
            pad_oe_o[p]          = func_oe_i[r_sel[p]][p];
            func_i_o[r_sel[p]][p] = w_pad_in[p];
         end
      end
   end

   assign reg_ready_o = r_ready;
   assign reg_rdata_o = r_rdata;
   assign reg_error_o = r_error;

endmodule
